// File: rtl/pattern_pkg.sv
// ============================================================================
//  Module   : pattern_pkg
//  Purpose  : Shared op encodings, default width and issuer FSM states.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package pattern_pkg;

   localparam int PATTERN_W = 4;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_AND = 2'b01;
   localparam logic [1:0] OP_OR  = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/pattern_op_fifo.sv
// ============================================================================
//  Module   : pattern_op_fifo
//  Purpose  : Circular show-ahead FIFO holding {op,A,B} request entries.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pattern_op_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             push,
   input  logic [WIDTH-1:0] pushData,
   input  logic             pop,
   output logic [WIDTH-1:0] popData,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] C_FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [AW:0]      r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign w_doPush = push && !full;
   assign w_doPop  = pop && !empty;
   assign empty    = (r_count == '0);
   assign full     = (r_count == C_FULL_COUNT);
   assign popData  = r_mem[r_rdPtr];

   // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
         r_count <= r_count + (AW+1)'(w_doPush) - (AW+1)'(w_doPop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_doPush) r_mem[r_wrPtr] <= pushData;
   end

endmodule

`default_nettype wire

// File: rtl/pattern_op_issuer.sv
// ============================================================================
//  Module   : pattern_op_issuer
//  Purpose  : Buffers AND/OR requests, drives the pattern logic stage and
//             returns its result. Optional checker: PATTERN_OP_ISSUER_CHECK_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pattern_op_issuer
   import pattern_pkg::*;
#(
   parameter int W     = PATTERN_W,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rstN,
   input  logic         reqValid,
   output logic         reqReady,
   input  logic [1:0]   reqOp,
   input  logic [W-1:0] reqA,
   input  logic [W-1:0] reqB,
   output logic [W-1:0] aIn,
   output logic [W-1:0] bIn,
   output logic         doAnd,
   output logic         doOr,
   input  logic [W-1:0] resIn,
   input  logic         resIsAnd,
   output logic         rspValid,
   input  logic         rspReady,
   output logic [W-1:0] rspData,
   output logic         rspIsAnd,
   output logic         rspErr
`ifdef PATTERN_OP_ISSUER_CHECK_EN
   ,
   output logic         chkErr
`endif
);

   localparam int FW = 2 + 2*W;

   logic [1:0]    r_state;
   logic [1:0]    w_nextState;
   logic [1:0]    r_op;
   logic [FW-1:0] w_fifoData;
   logic          w_empty;
   logic          w_full;
   logic          w_push;
   logic          w_load;
   logic          w_capture;
   logic          w_rspDone;

   assign reqReady = rstN && !w_full;
   assign w_push   = reqValid && reqReady;

   pattern_op_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rstN     (rstN),
      .push     (w_push),
      .pushData ({reqOp, reqA, reqB}),
      .pop      (w_load),
      .popData  (w_fifoData),
      .empty    (w_empty),
      .full     (w_full)
   );

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) r_state <= ST_IDLE;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE:  if (!w_empty) w_nextState = ST_ISSUE;
         ST_ISSUE: w_nextState = ST_RESP;
         ST_RESP:  if (rspReady) w_nextState = w_empty ? ST_IDLE : ST_ISSUE;
         default:  w_nextState = ST_IDLE;
      endcase
   end

   // A completed response may immediately pop the next queued op.
   always_comb begin
      w_rspDone = (r_state == ST_RESP) && rspReady;
      w_capture = (r_state == ST_ISSUE);
      w_load    = !w_empty && ((r_state == ST_IDLE) || w_rspDone);
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         aIn      <= '0;
         bIn      <= '0;
         doAnd    <= 1'b0;
         doOr     <= 1'b0;
         r_op     <= OP_NOP;
         rspValid <= 1'b0;
         rspData  <= '0;
         rspIsAnd <= 1'b0;
         rspErr   <= 1'b0;
      end else begin
         if (w_load) begin
            r_op  <= w_fifoData[FW-1 -: 2];
            aIn   <= w_fifoData[2*W-1 -: W];
            bIn   <= w_fifoData[W-1:0];
            doAnd <= (w_fifoData[FW-1 -: 2] == OP_AND);
            doOr  <= (w_fifoData[FW-1 -: 2] == OP_OR);
         end else if (w_rspDone) begin
            doAnd <= 1'b0;
            doOr  <= 1'b0;
         end
         if (w_capture) begin
            rspData  <= (r_op == OP_ILL) ? '0 : resIn;
            rspIsAnd <= (r_op == OP_AND);
            rspErr   <= (r_op == OP_ILL);
            rspValid <= 1'b1;
         end else if (w_rspDone) begin
            rspValid <= 1'b0;
         end
      end
   end

`ifdef PATTERN_OP_ISSUER_CHECK_EN
   logic w_chkHit;

   always_comb begin
      w_chkHit = 1'b0;
      if ((r_op == OP_AND) || (r_op == OP_OR)) w_chkHit = (resIsAnd != (r_op == OP_AND));
      else if (r_op == OP_NOP)                 w_chkHit = (resIn != '0);
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN)                      chkErr <= 1'b0;
      else if (w_capture && w_chkHit) chkErr <= 1'b1;
   end
`else
   logic w_unused;
   assign w_unused = resIsAnd;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pattern_op_issuer.sv
// ============================================================================
//  Module   : tb_pattern_op_issuer
//  Purpose  : Self-checking bench for pattern_op_issuer with a logic-stage
//             model and a response queue model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pattern_op_issuer;
   import pattern_pkg::*;

   localparam int W     = 4;
   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         rstN = 1'b0;
   logic         reqValid, reqReady;
   logic [1:0]   reqOp;
   logic [W-1:0] reqA, reqB, aIn, bIn, resIn, rspData;
   logic         doAnd, doOr, resIsAnd, rspValid, rspReady, rspIsAnd, rspErr;
   logic         forceIsAndLow = 1'b0;
`ifdef PATTERN_OP_ISSUER_CHECK_EN
   logic         chkErr;
`endif

   always #5 clk = ~clk;

   // Combinational AND/OR pattern logic stage.
   assign resIn    = doAnd ? (aIn & bIn) : (doOr ? (aIn | bIn) : '0);
   assign resIsAnd = forceIsAndLow ? 1'b0 : doAnd;

   pattern_op_issuer #(.W(W), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rstN     (rstN),
      .reqValid (reqValid),
      .reqReady (reqReady),
      .reqOp    (reqOp),
      .reqA     (reqA),
      .reqB     (reqB),
      .aIn      (aIn),
      .bIn      (bIn),
      .doAnd    (doAnd),
      .doOr     (doOr),
      .resIn    (resIn),
      .resIsAnd (resIsAnd),
      .rspValid (rspValid),
      .rspReady (rspReady),
      .rspData  (rspData),
      .rspIsAnd (rspIsAnd),
      .rspErr   (rspErr)
`ifdef PATTERN_OP_ISSUER_CHECK_EN
      ,
      .chkErr   (chkErr)
`endif
   );

   typedef struct packed {
      logic [W-1:0] data;
      logic         isAnd;
      logic         err;
   } rsp_t;

   rsp_t       expQ[$];
   rsp_t       e;
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         rspCyc[$];
   bit         measure = 1'b0;
   bit         prevHold = 1'b0;
   logic [6:0] held;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic rsp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      rsp_t r;
      r.data  = (op == OP_AND) ? (a & b) : ((op == OP_OR) ? (a | b) : '0);
      r.isAnd = (op == OP_AND);
      r.err   = (op == OP_ILL);
      return r;
   endfunction

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!rstN) begin
         prevHold = 1'b0;
      end else begin
         check("excl", 32'(doAnd && doOr), 32'd0);
         if (prevHold) check("hold", 32'({rspValid, rspData, rspIsAnd, rspErr}), 32'(held));
         prevHold = rspValid && !rspReady;
         held     = {rspValid, rspData, rspIsAnd, rspErr};
         if (rspValid && rspReady) begin
            if (expQ.size() == 0) begin
               check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               e = expQ.pop_front();
               check("rsp_data", 32'(rspData), 32'(e.data));
               check("rsp_isand", 32'(rspIsAnd), 32'(e.isAnd));
               check("rsp_err", 32'(rspErr), 32'(e.err));
            end
            if (measure) rspCyc.push_back(cyc);
         end
         if (reqValid && reqReady) expQ.push_back(model(reqOp, reqA, reqB));
      end
   end

   task automatic tryPush(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int bound, output bit ok);
      int n;
      n = 0;
      reqValid = 1'b1; reqOp = op; reqA = a; reqB = b;
      @(negedge clk);
      while (!reqReady && n < bound) begin
         n++;
         @(negedge clk);
      end
      ok = reqReady;
      @(posedge clk); #1;
      reqValid = 1'b0;
   endtask

   task automatic pushOne(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bit ok;
      tryPush(op, a, b, 200, ok);
      if (!ok) check("push_timeout", 32'd1, 32'd0);
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while ((expQ.size() != 0 || rspValid) && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_q", 32'(expQ.size()), 32'd0);
      check("drain_valid", 32'(rspValid), 32'd0);
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_aIn"}, 32'(aIn), 32'd0);
      check({tag, "_bIn"}, 32'(bIn), 32'd0);
      check({tag, "_doAnd"}, 32'(doAnd), 32'd0);
      check({tag, "_doOr"}, 32'(doOr), 32'd0);
      check({tag, "_rspValid"}, 32'(rspValid), 32'd0);
      check({tag, "_rspData"}, 32'(rspData), 32'd0);
      check({tag, "_rspIsAnd"}, 32'(rspIsAnd), 32'd0);
      check({tag, "_rspErr"}, 32'(rspErr), 32'd0);
      check({tag, "_reqReady"}, 32'(reqReady), 32'd0);
   endtask

   task automatic doReset();
      rstN = 1'b0;
      expQ.delete();
      @(posedge clk); #1;
      checkAllZero("rst");
      @(posedge clk); #1;
      rstN = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int accepted;
      int n;
      reqValid = 1'b0; reqOp = OP_NOP; reqA = '0; reqB = '0; rspReady = 1'b0;

      doReset();

      // Directed AND with cycle-exact latency.
      rspReady = 1'b1;
      reqValid = 1'b1; reqOp = OP_AND; reqA = 4'b1100; reqB = 4'b1010;
      @(negedge clk);
      check("t1_ready", 32'(reqReady), 32'd1);
      @(posedge clk); #1;
      reqValid = 1'b0;
      @(posedge clk); #1;
      check("t1_doAnd", 32'(doAnd), 32'd1);
      check("t1_doOr", 32'(doOr), 32'd0);
      check("t1_aIn", 32'(aIn), 32'b1100);
      check("t1_bIn", 32'(bIn), 32'b1010);
      check("t1_noValid", 32'(rspValid), 32'd0);
      @(posedge clk); #1;
      check("t1_valid", 32'(rspValid), 32'd1);
      check("t1_data", 32'(rspData), 32'b1000);
      check("t1_isAnd", 32'(rspIsAnd), 32'd1);
      check("t1_err", 32'(rspErr), 32'd0);
      waitDrain();

      // OR, NOP, illegal back to back.
      pushOne(OP_OR, 4'b0101, 4'b0011);
      pushOne(OP_NOP, 4'($urandom), 4'($urandom));
      pushOne(OP_ILL, 4'($urandom), 4'($urandom));
      waitDrain();

      // Backpressure: fill the FIFO while a response is held.
      rspReady = 1'b0;
      accepted = 0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         tryPush($urandom_range(0, 1) ? OP_AND : OP_OR, 4'($urandom), 4'($urandom), 5, ok);
         accepted += int'(ok);
      end
      check("bp_accepted", 32'(accepted), 32'(DEPTH + 1));
      check("bp_ready_low", 32'(reqReady), 32'd0);
      check("bp_valid", 32'(rspValid), 32'd1);
      repeat (5) begin @(posedge clk); #1; end
      rspReady = 1'b1;
      waitDrain();

      // Streaming throughput.
      rspCyc.delete();
      measure = 1'b1;
      for (int i = 0; i < 20; i++)
         pushOne($urandom_range(0, 1) ? OP_AND : OP_OR, 4'($urandom), 4'($urandom));
      waitDrain();
      measure = 1'b0;
      check("tp_count", 32'(rspCyc.size()), 32'd20);
      for (int i = 1; i < rspCyc.size(); i++)
         check("tp_gap", 32'(rspCyc[i] - rspCyc[i-1]), 32'd2);

      // Reset while in RESP with three entries queued.
      rspReady = 1'b0;
      for (int i = 0; i < 4; i++) pushOne(OP_OR, 4'($urandom), 4'($urandom));
      n = 0;
      while (!rspValid && n < 20) begin @(posedge clk); #1; n++; end
      check("mid_valid", 32'(rspValid), 32'd1);
      #2;
      rstN = 1'b0;
      #1;
      checkAllZero("mid");
      expQ.delete();
      @(posedge clk); #1;
      rstN = 1'b1;
      rspReady = 1'b1;
      repeat (10) begin @(posedge clk); #1; end
      check("post_valid", 32'(rspValid), 32'd0);
      check("post_ready", 32'(reqReady), 32'd1);

      // Random mixed traffic with random response backpressure.
      fork
         begin
            for (int i = 0; i < 30; i++) begin
               pushOne(2'($urandom), 4'($urandom), 4'($urandom));
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
         end
         begin
            repeat (150) begin
               @(posedge clk); #1;
               rspReady = 1'($urandom_range(0, 1));
            end
         end
      join
      rspReady = 1'b1;
      waitDrain();

`ifdef PATTERN_OP_ISSUER_CHECK_EN
      check("chk_clean", 32'(chkErr), 32'd0);
      forceIsAndLow = 1'b1;
      pushOne(OP_AND, 4'b1111, 4'b0110);
      waitDrain();
      forceIsAndLow = 1'b0;
      check("chk_set", 32'(chkErr), 32'd1);
      pushOne(OP_OR, 4'b0001, 4'b0010);
      waitDrain();
      check("chk_sticky", 32'(chkErr), 32'd1);
      doReset();
      check("chk_cleared", 32'(chkErr), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
